// File: rtl/timing_pkg.sv
// Shared timing constants and controller state encoding for the 5 MHz timing domain.
package timing_pkg;

  localparam int unsigned CLK_HZ         = 5_000_000;
  localparam int unsigned TICKS_PER_US   = 5;

  // Default strobe: one pulse per second, one microsecond high, free-running.
  localparam int unsigned DEFAULT_PERIOD = CLK_HZ;
  localparam int unsigned DEFAULT_WIDTH  = TICKS_PER_US;
  localparam int unsigned DEFAULT_COUNT  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_train_ctrl_if.sv
// Host-side handshake and status bundle of the pulse-train controller.
interface pulse_train_ctrl_if #(
  parameter int CNT_W = 23,
  parameter int NUM_W = 8
);

  logic             start;
  logic             abort;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] width;
  logic [NUM_W-1:0] count;
  logic             pulse_out;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic [NUM_W-1:0] pulse_idx;

  modport master (
    output start, abort, period, width, count,
    input  pulse_out, busy, done, cfg_err, pulse_idx
  );

  modport slave (
    input  start, abort, period, width, count,
    output pulse_out, busy, done, cfg_err, pulse_idx
  );

endinterface

// File: rtl/tick_counter.sv
// Clear/enable tick counter; term flags the cycle whose tick number equals target.
module tick_counter #(
  parameter int CNT_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] target,
  output logic             term
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Counter holds ticks already elapsed in the current phase, so cnt_r+1 is this cycle's tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign term = ((cnt_r + ONE) == target);

endmodule

// File: rtl/pulse_train_ctrl.sv
// Pulse-train controller: latches period/width/count on start and plays out the train.
module pulse_train_ctrl
  import timing_pkg::*;
#(
  parameter int CNT_W = 23,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  pulse_train_ctrl_if.slave bus
);

  localparam logic [NUM_W-1:0] IDX_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [CNT_W-1:0] period_r;
  logic [CNT_W-1:0] width_r;
  logic [NUM_W-1:0] count_r;
  logic [NUM_W-1:0] pulse_idx_r;
  logic             pulse_r;
  logic             busy_r;
  logic             done_r;
  logic             cfg_err_r;

  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic             cnt_term_s;
  logic [CNT_W-1:0] cnt_target_s;
  logic             last_pulse_s;

  // width>=1 together with width<period already forces period>=2.
  function automatic logic cfg_legal(input logic [CNT_W-1:0] p, input logic [CNT_W-1:0] w);
    return (w != '0) && (w < p);
  endfunction

  assign cnt_target_s = (state_r == HIGH) ? width_r : period_r;
  assign last_pulse_s = (count_r != '0) && (pulse_idx_r == (count_r - IDX_ONE));

  // Counter runs through HIGH into LOW and restarts at each period boundary; held clear when idle.
  always_comb begin
    cnt_clr_s = 1'b1;
    cnt_en_s  = 1'b0;
    case (state_r)
      HIGH: begin
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b1;
      end
      LOW: begin
        cnt_clr_s = cnt_term_s;
        cnt_en_s  = ~cnt_term_s;
      end
      default: begin
        cnt_clr_s = 1'b1;
        cnt_en_s  = 1'b0;
      end
    endcase
  end

  tick_counter #(.CNT_W(CNT_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_s),
    .en     (cnt_en_s),
    .target (cnt_target_s),
    .term   (cnt_term_s)
  );

  // Controller FSM with config latches and registered outputs/strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      period_r    <= '0;
      width_r     <= '0;
      count_r     <= '0;
      pulse_idx_r <= '0;
      pulse_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            if (cfg_legal(bus.period, bus.width)) begin
              period_r    <= bus.period;
              width_r     <= bus.width;
              count_r     <= bus.count;
              pulse_idx_r <= '0;
              state_r     <= HIGH;
              pulse_r     <= 1'b1;
              busy_r      <= 1'b1;
            end else begin
              cfg_err_r <= 1'b1;
            end
          end
        end
        HIGH: begin
          if (bus.abort) begin
            state_r <= IDLE;
            pulse_r <= 1'b0;
            busy_r  <= 1'b0;
          end else if (cnt_term_s) begin
            state_r <= LOW;
            pulse_r <= 1'b0;
          end
        end
        LOW: begin
          if (bus.abort) begin
            state_r <= IDLE;
            pulse_r <= 1'b0;
            busy_r  <= 1'b0;
          end else if (cnt_term_s) begin
            if (last_pulse_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              // Continuous mode relies on the natural NUM_W wrap here.
              pulse_idx_r <= pulse_idx_r + IDX_ONE;
              state_r     <= HIGH;
              pulse_r     <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          pulse_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pulse_out = pulse_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.cfg_err   = cfg_err_r;
  assign bus.pulse_idx = pulse_idx_r;

endmodule
